// File: rtl/alu_pkg.sv
// Shared definitions for the alu datapath and the arbiter that feeds it.
// Holds the opcode width, opcode encodings and the arbiter FSM state type.
// No logic; imported by alu_arbiter and rr_arbiter.
package alu_pkg;

  localparam int ALU_OP_W = 2;

  // Opcode encodings understood by the alu.
  localparam logic [ALU_OP_W-1:0] OP_ADD = 2'd0;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 2'd1;
  localparam logic [ALU_OP_W-1:0] OP_AND = 2'd2;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } alu_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: first requester at or after ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides whether the grant is used.
// Ports: req (per-requester valid), ptr (search start index),
//        grant (one-hot, zero when no request), grant_id (binary index of grant).
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic found;
  int   idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered alu among NUM_REQ requesters: round-robin accept, drive alu, capture, respond.
// Latency: accept in cycle 0, rsp_valid high in cycle ALU_LAT+2; one op per ALU_LAT+3 cycles at best.
// Backpressure: response held indefinitely until rsp_ready; no new accept until the response drains.
// Ports: req_valid/req_op/req_a/req_b in, req_ready out (one-hot accept strobe);
//        alu_in1/alu_in2/alu_op to the alu, alu_out/alu_z back from it;
//        rsp_valid/rsp_id/rsp_data/rsp_z out with rsp_ready in; busy high outside IDLE.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N       = 12,
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ALU_OP_W-1:0]   req_op,
  input  logic [NUM_REQ*N-1:0]          req_a,
  input  logic [NUM_REQ*N-1:0]          req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [N-1:0]                  alu_in1,
  output logic [N-1:0]                  alu_in2,
  output logic [ALU_OP_W-1:0]           alu_op,
  input  logic [N-1:0]                  alu_out,
  input  logic [N-1:0]                  alu_z,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [N-1:0]                  rsp_data,
  output logic                          rsp_z,
  output logic                          busy
);

  localparam int CNT_W = $clog2(ALU_LAT + 1);

  alu_arb_state_t      state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W-1:0]     id_q;
  logic [NUM_REQ-1:0]  gnt;
  logic [CNT_W-1:0]    cnt;
  logic                accept;

  // The alu drives a full-width zero bus; only its LSB carries the flag.
  logic                unused_alu_z;
  assign unused_alu_z = ^alu_z[N-1:1];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (gnt),
    .grant_id (gnt_id)
  );

  assign accept    = (state == IDLE) && (|req_valid);
  assign req_ready = (state == IDLE) ? gnt : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      // cnt is loaded with ALU_LAT, so leaving at 1 gives exactly ALU_LAT cycles in EXEC.
      EXEC:    if (cnt == CNT_W'(1)) state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      cnt       <= '0;
      id_q      <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_z     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_op  <= req_op[ALU_OP_W*int'(gnt_id) +: ALU_OP_W];
            alu_in1 <= req_a[N*int'(gnt_id) +: N];
            alu_in2 <= req_b[N*int'(gnt_id) +: N];
            id_q    <= gnt_id;
            rr_ptr  <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            cnt     <= CNT_W'(ALU_LAT);
          end
        end
        EXEC: cnt <= cnt - 1'b1;
        CAPT: begin
          rsp_data  <= alu_out;
          rsp_z     <= alu_z[0];
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: default instance (ALU_LAT=1) plus an ALU_LAT=3 instance,
// each with a behavioural registered alu. Expected responses go into a queue when
// a request is accepted and are popped when the DUT raises rsp_valid.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N  = 12;
  localparam int NR = 4;

  typedef struct packed {
    logic [1:0]   id;
    logic [N-1:0] data;
    logic         z;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;

  logic [NR-1:0]   req_valid;
  logic [NR*2-1:0] req_op;
  logic [NR*N-1:0] req_a, req_b;
  logic [NR-1:0]   req_ready;
  logic [N-1:0]    alu_in1, alu_in2, alu_out, alu_z;
  logic [1:0]      alu_op;
  logic            rsp_valid, rsp_ready, rsp_z, busy;
  logic [1:0]      rsp_id;
  logic [N-1:0]    rsp_data;

  logic [NR-1:0]   l3_req_valid;
  logic [NR*2-1:0] l3_req_op;
  logic [NR*N-1:0] l3_req_a, l3_req_b;
  logic [NR-1:0]   l3_req_ready;
  logic [N-1:0]    l3_alu_in1, l3_alu_in2, l3_alu_out, l3_alu_z, l3_p1, l3_p2;
  logic [1:0]      l3_alu_op;
  logic            l3_rsp_valid, l3_rsp_ready, l3_rsp_z, l3_busy;
  logic [1:0]      l3_rsp_id;
  logic [N-1:0]    l3_rsp_data;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   lat;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N), .NUM_REQ(NR), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_op(alu_op), .alu_out(alu_out), .alu_z(alu_z), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_z(rsp_z),
    .busy(busy)
  );

  alu_arbiter #(.N(N), .NUM_REQ(NR), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(l3_req_valid), .req_op(l3_req_op), .req_a(l3_req_a),
    .req_b(l3_req_b), .req_ready(l3_req_ready), .alu_in1(l3_alu_in1), .alu_in2(l3_alu_in2),
    .alu_op(l3_alu_op), .alu_out(l3_alu_out), .alu_z(l3_alu_z), .rsp_valid(l3_rsp_valid),
    .rsp_ready(l3_rsp_ready), .rsp_id(l3_rsp_id), .rsp_data(l3_rsp_data), .rsp_z(l3_rsp_z),
    .busy(l3_busy)
  );

  function automatic logic [N-1:0] alu_f(input logic [1:0] op, input logic [N-1:0] a, b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      default: return a | b;
    endcase
  endfunction

  // 1-cycle alu; upper zero-flag bits forced to 1 so only bit 0 may matter.
  always @(posedge clk) begin
    alu_out <= alu_f(alu_op, alu_in1, alu_in2);
    alu_z   <= {{(N-1){1'b1}}, alu_f(alu_op, alu_in1, alu_in2) == '0};
  end

  // 3-cycle pipelined alu for the ALU_LAT=3 instance.
  always @(posedge clk) begin
    l3_p1      <= alu_f(l3_alu_op, l3_alu_in1, l3_alu_in2);
    l3_p2      <= l3_p1;
    l3_alu_out <= l3_p2;
    l3_alu_z   <= {{(N-1){1'b0}}, l3_p2 == '0};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic [1:0] op, input logic [N-1:0] a, b);
    req_valid[i]      = 1'b1;
    req_op[2*i +: 2]  = op;
    req_a[N*i +: N]   = a;
    req_b[N*i +: N]   = b;
  endtask

  function automatic exp_t mk_exp(input int i);
    exp_t r;
    r.id   = 2'(i);
    r.data = alu_f(req_op[2*i +: 2], req_a[N*i +: N], req_b[N*i +: N]);
    r.z    = (r.data == '0);
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  // Waits up to max cycles for rsp_valid; drops the accepted requesters one cycle after accept.
  task automatic wait_rsp(input logic [NR-1:0] clr, input int max, output int l);
    l = -1;
    for (int c = 1; c <= max; c++) begin
      @(posedge clk); #1;
      if (c == 1) req_valid = req_valid & ~clr;
      if (rsp_valid) begin
        l = c;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    l3_req_valid = '0; l3_req_op = '0; l3_req_a = '0; l3_req_b = '0; l3_rsp_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({rsp_valid, busy, req_ready} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000", {rsp_valid, busy, req_ready});
    end
    checks++;
    if ({alu_in1, alu_in2, alu_op} !== '0) begin
      errors++; $display("FAIL reset_alu got %h %h %h want 0", alu_in1, alu_in2, alu_op);
    end
    checks++;
    if ({rsp_id, rsp_data, rsp_z} !== '0) begin
      errors++; $display("FAIL reset_rsp got %h %h %b want 0", rsp_id, rsp_data, rsp_z);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_req(2, OP_ADD, 12'd5, 12'd10); #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_grant got %b want 0100", req_ready);
    end
    exp_q.push_back(mk_exp(2));
    wait_rsp(4'b0100, 8, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL single_latency got %0d want 3", lat); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL single_rsp got response want none queued"); end
    else begin
      e = exp_q.pop_front();
      if ({rsp_id, rsp_data, rsp_z} !== e) begin
        errors++; $display("FAIL single_rsp got %0d/%0d/%b want %0d/%0d/%b",
                           rsp_id, rsp_data, rsp_z, e.id, e.data, e.z);
      end
    end
    checks++;
    if ({alu_in1, alu_in2, alu_op} !== {12'd5, 12'd10, 2'd0}) begin
      errors++; $display("FAIL single_operands got %0d %0d %0d want 5 10 0", alu_in1, alu_in2, alu_op);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] m;
    int g;
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 2'(i % 2), 12'(100 * (i + 1)), 12'(7 * i + 1));
    for (int k = 0; k < 5; k++) begin
      #1;
      g = k % NR;
      m = 4'b0001 << g;
      checks++;
      if (req_ready !== m) begin
        errors++; $display("FAIL rr_grant_%0d got %b want %b", k, req_ready, m);
      end
      exp_q.push_back(mk_exp(g));
      wait_rsp(m, 8, lat);
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL rr_rsp_%0d got response want none queued", k); end
      else begin
        e = exp_q.pop_front();
        if (lat !== 3 || {rsp_id, rsp_data, rsp_z} !== e) begin
          errors++; $display("FAIL rr_rsp_%0d got lat %0d %0d/%0d/%b want lat 3 %0d/%0d/%b",
                             k, lat, rsp_id, rsp_data, rsp_z, e.id, e.data, e.z);
        end
      end
      set_req(g, 2'(g % 2), 12'(100 * (g + 1) + k), 12'(3 * k));
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_zero();
    set_req(1, OP_SUB, 12'd30, 12'd30); #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL zero_grant got %b want 0010", req_ready); end
    exp_q.push_back(mk_exp(1));
    wait_rsp(4'b0010, 8, lat);
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL zero_rsp got response want none queued"); end
    else begin
      e = exp_q.pop_front();
      if ({rsp_id, rsp_data, rsp_z} !== e || rsp_z !== 1'b1) begin
        errors++; $display("FAIL zero_rsp got %0d/%0d/%b want %0d/%0d/1",
                           rsp_id, rsp_data, rsp_z, e.id, e.data);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [2+N:0] snap;
    rsp_ready = 1'b0;
    set_req(0, OP_ADD, 12'd100, 12'd23);
    set_req(3, OP_SUB, 12'd9, 12'd40); #1;
    // pointer sits at 2 here, so requester 3 wins before 0 (and the pointer wraps)
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant got %b want 1000", req_ready); end
    exp_q.push_back(mk_exp(3));
    wait_rsp(4'b1000, 8, lat);
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL bp_rsp got response want none queued"); end
    else begin
      e = exp_q.pop_front();
      if (lat !== 3 || {rsp_id, rsp_data, rsp_z} !== e) begin
        errors++; $display("FAIL bp_rsp got lat %0d %0d/%0d/%b want lat 3 %0d/%0d/%b",
                           lat, rsp_id, rsp_data, rsp_z, e.id, e.data, e.z);
      end
    end
    snap = {rsp_id, rsp_data, rsp_z};
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_z} !== {1'b1, snap} || req_ready !== '0 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold_%0d got v%b %h rdy %b busy %b want v1 %h rdy 0000 busy 1",
                           c, rsp_valid, {rsp_id, rsp_data, rsp_z}, req_ready, busy, snap);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1; #1;
    checks++;
    if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_resume got rdy %b v %b want rdy 0001 v 0", req_ready, rsp_valid);
    end
    exp_q.push_back(mk_exp(0));
    wait_rsp(4'b0001, 8, lat);
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL bp_rsp2 got response want none queued"); end
    else begin
      e = exp_q.pop_front();
      if ({rsp_id, rsp_data, rsp_z} !== e) begin
        errors++; $display("FAIL bp_rsp2 got %0d/%0d/%b want %0d/%0d/%b",
                           rsp_id, rsp_data, rsp_z, e.id, e.data, e.z);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    set_req(2, OP_ADD, 12'd11, 12'd22); #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL rmid_grant got %b want 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1; #1;
    checks++;
    if ({busy, rsp_valid, req_ready} !== 6'b0 || {alu_in1, alu_in2, alu_op} !== '0) begin
      errors++; $display("FAIL rmid_clear got busy %b v %b alu %h %h %h want all 0",
                         busy, rsp_valid, alu_in1, alu_in2, alu_op);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rmid_quiet_%0d got v %b busy %b want 0 0", c, rsp_valid, busy);
      end
    end
    set_req(1, OP_ADD, 12'd1, 12'd2);
    set_req(3, OP_OR, 12'h0F0, 12'h00F); #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_ptr got %b want 0010", req_ready); end
    exp_q.push_back(mk_exp(1));
    wait_rsp(4'b0010, 8, lat);
    req_valid = '0;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL rmid_rsp got response want none queued"); end
    else begin
      e = exp_q.pop_front();
      if ({rsp_id, rsp_data, rsp_z} !== e) begin
        errors++; $display("FAIL rmid_rsp got %0d/%0d/%b want %0d/%0d/%b",
                           rsp_id, rsp_data, rsp_z, e.id, e.data, e.z);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lat3();
    l3_req_valid[0]  = 1'b1;
    l3_req_op[1:0]   = OP_ADD;
    l3_req_a[N-1:0]  = 12'd4;
    l3_req_b[N-1:0]  = 12'd20; #1;
    checks++;
    if (l3_req_ready !== 4'b0001) begin errors++; $display("FAIL lat3_grant got %b want 0001", l3_req_ready); end
    exp_q.push_back(exp_t'{2'd0, 12'd24, 1'b0});
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) l3_req_valid = '0;
      if (l3_rsp_valid) begin lat = c; break; end
    end
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL lat3_latency got %0d want 5", lat); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL lat3_rsp got response want none queued"); end
    else begin
      e = exp_q.pop_front();
      if ({l3_rsp_id, l3_rsp_data, l3_rsp_z} !== e) begin
        errors++; $display("FAIL lat3_rsp got %0d/%0d/%b want %0d/%0d/%b",
                           l3_rsp_id, l3_rsp_data, l3_rsp_z, e.id, e.data, e.z);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_lat3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
